// File: rtl/mips_controller_pkg.sv
// Shared encodings for the TinyMIPS multicycle controller: opcodes, funct codes,
// FSM states, ALU codes and the per-state control word.
package mips_controller_pkg;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic [3:0] irwrite;
    logic       memtoreg;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsource;
    logic       regdst;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for each state; anything not set stays 0 (aluop 00 = add).
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
        c.irwrite = 4'b0001 << (s - S_FETCH1);
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_LBRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_SBWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALUOP_SUB;
        c.branch   = 1'b1;
        c.pcsource = 2'b01;
      end
      S_JEX: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
      S_ADDIWR:  c.regwrite = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Combinational ALU control decode from aluop and the R-type funct field.
module alu_decoder
  import mips_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUCTL_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUCTL_ADD;
      ALUOP_SUB: alucontrol = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        // Unrecognised funct falls back to add; the register write still happens.
        case (funct)
          FUNCT_ADD: alucontrol = ALUCTL_ADD;
          FUNCT_SUB: alucontrol = ALUCTL_SUB;
          FUNCT_AND: alucontrol = ALUCTL_AND;
          FUNCT_OR:  alucontrol = ALUCTL_OR;
          FUNCT_SLT: alucontrol = ALUCTL_SLT;
          default:   alucontrol = ALUCTL_ADD;
        endcase
      end
      default:   alucontrol = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit TinyMIPS datapath: byte-wise fetch,
// decode and execute of LB, SB, R-type, BEQ, J and ADDI.
module mips_controller
  import mips_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic       regdst,
  output logic       regwrite,
  output logic [2:0] alucontrol
);

  state_t     state_reg;
  state_t     state_next;
  ctrl_t      ctrl;
  logic [2:0] alucontrol_raw;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH1;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH1;
    case (state_reg)
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: state_next = S_FETCH3;
      S_FETCH3: state_next = S_FETCH4;
      S_FETCH4: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_J:         state_next = S_JEX;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_FETCH1;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SB) ? S_SBWR : S_LBRD;
      S_LBRD:    state_next = S_LBWR;
      S_RTYPEEX: state_next = S_RTYPEWR;
      S_ADDIEX:  state_next = S_ADDIWR;
      default:   state_next = S_FETCH1;
    endcase
  end

  // Reset blanks every output immediately, not just from the next edge.
  assign ctrl = reset ? '0 : state_ctrl(state_reg);

  alu_decoder u_alu_decoder (
    .aluop      (ctrl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol_raw)
  );

  assign memread    = ctrl.memread;
  assign memwrite   = ctrl.memwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite;
  assign memtoreg   = ctrl.memtoreg;
  assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
  assign pcsource   = ctrl.pcsource;
  assign regdst     = ctrl.regdst;
  assign regwrite   = ctrl.regwrite;
  assign alucontrol = reset ? 3'b000 : alucontrol_raw;

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: per-cycle expected control vectors are
// queued by the stimulus process and checked by an independent negedge monitor.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, pcen, regdst, regwrite;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg), .pcen(pcen),
    .pcsource(pcsource), .regdst(regdst), .regwrite(regwrite), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Field order: memread memwrite alusrca alusrcb iord irwrite memtoreg pcen pcsource regdst regwrite alucontrol
  function automatic logic [18:0] mk(input logic mr, input logic mw, input logic sa,
                                     input logic [1:0] sb, input logic io, input logic [3:0] ir,
                                     input logic m2r, input logic pe, input logic [1:0] ps,
                                     input logic rd, input logic rw, input logic [2:0] ac);
    return {mr, mw, sa, sb, io, ir, m2r, pe, ps, rd, rw, ac};
  endfunction

  function automatic logic [18:0] fetch_v(input int n);
    logic [3:0] one = 4'b0001;
    return mk(1, 0, 0, 2'b01, 0, one << n, 0, 1, 2'b00, 0, 0, 3'b010);
  endfunction

  wire [18:0] actual = {memread, memwrite, alusrca, alusrcb, iord, irwrite,
                        memtoreg, pcen, pcsource, regdst, regwrite, alucontrol};

  // Monitor: one expected entry at most per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        tests_run++;
        if (actual !== e.v) begin
          tests_failed++;
          $display("FAIL %s got=%b expected=%b", e.name, actual, e.v);
        end else begin
          $display("ok   %s outputs=%b", e.name, actual);
        end
      end
    end
  end

  task automatic cyc(input string name, input logic [18:0] v);
    @(posedge clk); #1;
    exp_q.push_back('{name, v});
  endtask

  task automatic cyc_rst(input string name, input logic r, input logic [18:0] v);
    @(posedge clk); #1;
    reset = r;
    exp_q.push_back('{name, v});
  endtask

  // Inputs change only after the edge that leaves the previous instruction.
  task automatic fetch_decode(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
    @(posedge clk); #1;
    op = o; funct = f; zero = z;
    exp_q.push_back('{{name, "_fetch1"}, fetch_v(0)});
    cyc({name, "_fetch2"}, fetch_v(1));
    cyc({name, "_fetch3"}, fetch_v(2));
    cyc({name, "_fetch4"}, fetch_v(3));
    cyc({name, "_decode"}, mk(0, 0, 0, 2'b11, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 3'b010));
  endtask

  task automatic rtype(input string name, input logic [5:0] f, input logic [2:0] ac);
    fetch_decode(name, 6'b000000, f, 1'b0);
    cyc({name, "_ex"}, mk(0, 0, 1, 2'b00, 0, 4'b0000, 0, 0, 2'b00, 0, 0, ac));
    cyc({name, "_wr"}, mk(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 2'b00, 1, 1, 3'b010));
  endtask

  localparam logic [18:0] MEMADR_V = 19'b0_0_1_10_0_0000_0_0_00_0_0_010;

  initial begin
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    cyc_rst("reset_c1", 1'b1, '0);
    cyc_rst("reset_c2", 1'b1, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    exp_q.push_back('{"add_fetch1", fetch_v(0)});
    cyc("add_fetch2", fetch_v(1));
    cyc("add_fetch3", fetch_v(2));
    cyc("add_fetch4", fetch_v(3));
    cyc("add_decode", mk(0, 0, 0, 2'b11, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 3'b010));
    cyc("add_ex", mk(0, 0, 1, 2'b00, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 3'b010));
    cyc("add_wr", mk(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 2'b00, 1, 1, 3'b010));

    rtype("sub", 6'b100010, 3'b110);
    rtype("and", 6'b100100, 3'b000);
    rtype("or",  6'b100101, 3'b001);
    rtype("slt", 6'b101010, 3'b111);
    rtype("badfunct", 6'b000111, 3'b010);

    fetch_decode("beq_taken", 6'b000100, 6'b0, 1'b1);
    cyc("beq_taken_ex", mk(0, 0, 1, 2'b00, 0, 4'b0000, 0, 1, 2'b01, 0, 0, 3'b110));
    fetch_decode("beq_nottaken", 6'b000100, 6'b0, 1'b0);
    cyc("beq_nottaken_ex", mk(0, 0, 1, 2'b00, 0, 4'b0000, 0, 0, 2'b01, 0, 0, 3'b110));

    fetch_decode("j", 6'b000010, 6'b0, 1'b0);
    cyc("j_ex", mk(0, 0, 0, 2'b00, 0, 4'b0000, 0, 1, 2'b10, 0, 0, 3'b010));

    fetch_decode("lb", 6'b100000, 6'b0, 1'b0);
    cyc("lb_memadr", MEMADR_V);
    cyc("lb_rd", mk(1, 0, 0, 2'b00, 1, 4'b0000, 0, 0, 2'b00, 0, 0, 3'b010));
    cyc("lb_wr", mk(0, 0, 0, 2'b00, 0, 4'b0000, 1, 0, 2'b00, 0, 1, 3'b010));

    fetch_decode("sb", 6'b101000, 6'b0, 1'b0);
    cyc("sb_memadr", MEMADR_V);
    cyc("sb_wr", mk(0, 1, 0, 2'b00, 1, 4'b0000, 0, 0, 2'b00, 0, 0, 3'b010));

    fetch_decode("addi", 6'b001000, 6'b0, 1'b0);
    cyc("addi_ex", MEMADR_V);
    cyc("addi_wr", mk(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 2'b00, 0, 1, 3'b010));

    fetch_decode("undef", 6'b111111, 6'b0, 1'b0);

    // Abort an R-type in its execute cycle; the write must never appear.
    fetch_decode("abort", 6'b000000, 6'b100000, 1'b0);
    cyc_rst("abort_reset", 1'b1, '0);
    cyc_rst("abort_release_fetch1", 1'b0, fetch_v(0));
    cyc("abort_fetch2", fetch_v(1));
    cyc("abort_fetch3", fetch_v(2));
    cyc("abort_fetch4", fetch_v(3));
    cyc("abort_decode", mk(0, 0, 0, 2'b11, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 3'b010));
    cyc("abort_ex", mk(0, 0, 1, 2'b00, 0, 4'b0000, 0, 0, 2'b00, 0, 0, 3'b010));
    cyc("abort_wr", mk(0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 2'b00, 1, 1, 3'b010));
    cyc("final_fetch1", fetch_v(0));

    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
